// File: rtl/mem_arb_pkg.sv
// Shared constants and enums for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        REQ_CPU,
        REQ_GFX
    } req_id_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between the CPU and graphics requesters.
// Macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the CPU wins ties.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    gfx_req,
    input  req_id_e last_grant,
    output logic    grant,
    output req_id_e winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant  = cpu_req | gfx_req;
        winner = REQ_CPU;
        if (cpu_req && gfx_req)
            winner = (last_grant == REQ_CPU) ? REQ_GFX : REQ_CPU;
        else if (gfx_req)
            winner = REQ_GFX;
    end
`else
    // Fixed priority ignores the pointer; the graphics side may starve.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant  = cpu_req | gfx_req;
        winner = REQ_CPU;
        if (!cpu_req && gfx_req)
            winner = REQ_GFX;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the CPU and the sprite fetch engine.
// Tie-breaking is chosen in mem_arb_select (macro MEM_ARB_ROUND_ROBIN_EN); this FSM is macro-free.
module mem_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
    parameter int DATA_W       = mem_arb_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_MR_i,
    input  logic              cpu_MW_i,
    input  logic [ADDR_W-1:0] cpu_address_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_ack_o,
    input  logic              gfx_req_i,
    input  logic [ADDR_W-1:0] gfx_address_i,
    output logic [DATA_W-1:0] gfx_data_o,
    output logic              gfx_ack_o,
    output logic              mem_MR_o,
    output logic              mem_MW_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o
);
    import mem_arb_pkg::*;

    state_e            state, state_nxt;
    logic [2:0]        cnt;
    req_id_e           win, last_grant, sel;
    logic              grant;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, cpu_data, gfx_data;

    mem_arb_select u_select (
        .cpu_req    (cpu_req_i),
        .gfx_req    (gfx_req_i),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (sel)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            win        <= REQ_CPU;
            last_grant <= REQ_GFX;
            wr         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            cpu_data   <= '0;
            gfx_data   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (grant) begin
                    win        <= sel;
                    last_grant <= sel;
                    if (sel == REQ_CPU) begin
                        // Malformed MR/MW combinations fall back to a read.
                        wr    <= cpu_MW_i & ~cpu_MR_i;
                        addr  <= cpu_address_i;
                        wdata <= cpu_data_i;
                    end else begin
                        wr    <= 1'b0;
                        addr  <= gfx_address_i;
                        wdata <= '0;
                    end
                end
                ISSUE: if (!wr) cnt <= 3'(READ_LATENCY - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        if (win == REQ_CPU) cpu_data <= mem_data_i;
                        else                gfx_data <= mem_data_i;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        mem_MR_o      = 1'b0;
        mem_MW_o      = 1'b0;
        mem_address_o = '0;
        mem_data_o    = '0;
        cpu_ack_o     = 1'b0;
        gfx_ack_o     = 1'b0;
        busy_o        = (state != IDLE);
        case (state)
            IDLE:  if (grant) state_nxt = ISSUE;
            ISSUE: begin
                mem_MR_o      = ~wr;
                mem_MW_o      = wr;
                mem_address_o = addr;
                mem_data_o    = wdata;
                state_nxt     = wr ? DONE : WAIT;
            end
            WAIT:  if (cnt == '0) state_nxt = DONE;
            DONE: begin
                cpu_ack_o = (win == REQ_CPU);
                gfx_ack_o = (win == REQ_GFX);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_data_o = cpu_data;
    assign gfx_data_o = gfx_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: random transactions against a cycle-count/scoreboard model.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to check the round-robin tie-break.
module tb_mem_port_arbiter;
    localparam int RL = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cpu_req_i = 1'b0, cpu_MR_i = 1'b0, cpu_MW_i = 1'b0;
    logic [AW-1:0] cpu_address_i = '0;
    logic [DW-1:0] cpu_data_i = '0;
    logic [DW-1:0] cpu_data_o;
    logic          cpu_ack_o;
    logic          gfx_req_i = 1'b0;
    logic [AW-1:0] gfx_address_i = '0;
    logic [DW-1:0] gfx_data_o;
    logic          gfx_ack_o;
    logic          mem_MR_o, mem_MW_o;
    logic [AW-1:0] mem_address_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          busy_o;

    int            checks = 0, errors = 0;
    logic [DW-1:0] exp_cpu_data = '0, exp_gfx_data = '0;
    bit            last_gfx = 1'b1;

    mem_port_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_MR_i(cpu_MR_i), .cpu_MW_i(cpu_MW_i),
        .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o),
        .gfx_req_i(gfx_req_i), .gfx_address_i(gfx_address_i),
        .gfx_data_o(gfx_data_o), .gfx_ack_o(gfx_ack_o),
        .mem_MR_o(mem_MR_o), .mem_MW_o(mem_MW_o),
        .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns a fresh random word every cycle, so a wrong latency captures the wrong word.
    task automatic tick;
        @(posedge clk_i);
        #1;
        mem_data_i = $urandom;
    endtask

    // One transaction for a single requester starting from IDLE; ends in the following IDLE cycle.
    task automatic run_txn(input string tag, input bit gfx, input bit mr, input bit mw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit wr;
        int lat;
        logic [DW-1:0] cap;
        wr  = !gfx && mw && !mr;
        lat = wr ? 2 : RL + 2;
        cap = '0;
        if (gfx) begin
            gfx_req_i = 1'b1; gfx_address_i = a;
        end else begin
            cpu_req_i = 1'b1; cpu_MR_i = mr; cpu_MW_i = mw; cpu_address_i = a; cpu_data_i = d;
        end
        tick();
        checks++;
        if ({mem_MR_o, mem_MW_o, busy_o, cpu_ack_o, gfx_ack_o, mem_address_o} !== {!wr, wr, 3'b100, a}) begin
            errors++;
            $display("FAIL %s_issue: got %h want %h", tag,
                     {mem_MR_o, mem_MW_o, busy_o, cpu_ack_o, gfx_ack_o, mem_address_o}, {!wr, wr, 3'b100, a});
        end
        if (!gfx) begin
            checks++;
            if (mem_data_o !== d) begin
                errors++; $display("FAIL %s_wdata: got %h want %h", tag, mem_data_o, d);
            end
        end
        for (int c = 2; c < lat; c++) begin
            tick();
            if (c == RL + 1) cap = mem_data_i;
            checks++;
            if ({mem_MR_o, mem_MW_o, busy_o, cpu_ack_o, gfx_ack_o, mem_address_o} !== {5'b00100, {AW{1'b0}}}) begin
                errors++;
                $display("FAIL %s_wait%0d: got %h want %h", tag, c,
                         {mem_MR_o, mem_MW_o, busy_o, cpu_ack_o, gfx_ack_o, mem_address_o}, {5'b00100, {AW{1'b0}}});
            end
        end
        tick();
        if (!wr) begin
            if (gfx) exp_gfx_data = cap; else exp_cpu_data = cap;
        end
        last_gfx = gfx;
        checks++;
        if ({cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o, mem_MW_o} !== {!gfx, gfx, 3'b100}) begin
            errors++;
            $display("FAIL %s_ack: got %b want %b", tag,
                     {cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o, mem_MW_o}, {!gfx, gfx, 3'b100});
        end
        checks++;
        if ({cpu_data_o, gfx_data_o} !== {exp_cpu_data, exp_gfx_data}) begin
            errors++;
            $display("FAIL %s_rdata: got %h want %h", tag, {cpu_data_o, gfx_data_o}, {exp_cpu_data, exp_gfx_data});
        end
        cpu_req_i = 1'b0; gfx_req_i = 1'b0;
        tick();
        checks++;
        if ({cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o, mem_MW_o} !== 5'b0) begin
            errors++; $display("FAIL %s_idle: got %b want 00000", tag, {cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o, mem_MW_o});
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; cpu_req_i = 1'b1; cpu_MW_i = 1'b1; gfx_req_i = 1'b1;
        tick(); tick();
        checks++;
        if ({busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 00000", {busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o});
        end
        checks++;
        if ({mem_address_o, mem_data_o, cpu_data_o, gfx_data_o} !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {mem_address_o, mem_data_o, cpu_data_o, gfx_data_o});
        end
        cpu_req_i = 1'b0; cpu_MW_i = 1'b0; gfx_req_i = 1'b0; rst_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_write;
        run_txn("cpu_write", 1'b0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
    endtask

    task automatic test_read;
        run_txn("cpu_read", 1'b0, 1'b1, 1'b0, 10'h005, 32'h0);
        run_txn("gfx_read_top", 1'b1, 1'b1, 1'b0, 10'h3FF, 32'h0);
    endtask

    task automatic test_arbitration;
        bit w;
        logic [DW-1:0] cap;
        logic [AW-1:0] ca, ga;
        ca = AW'($urandom); ga = AW'($urandom); cap = '0;
        cpu_req_i = 1'b1; cpu_MR_i = 1'b1; cpu_MW_i = 1'b0; cpu_address_i = ca;
        gfx_req_i = 1'b1; gfx_address_i = ga;
        for (int n = 0; n < 6; n++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = !last_gfx;
`else
            w = 1'b0;
`endif
            tick();
            checks++;
            if ({mem_MR_o, mem_MW_o, mem_address_o} !== {2'b10, w ? ga : ca}) begin
                errors++;
                $display("FAIL arb%0d_issue: got %h want %h", n, {mem_MR_o, mem_MW_o, mem_address_o}, {2'b10, w ? ga : ca});
            end
            for (int c = 2; c <= RL + 1; c++) begin
                tick();
                if (c == RL + 1) cap = mem_data_i;
            end
            tick();
            if (w) exp_gfx_data = cap; else exp_cpu_data = cap;
            last_gfx = w;
            checks++;
            if ({cpu_ack_o, gfx_ack_o, cpu_data_o, gfx_data_o} !== {!w, w, exp_cpu_data, exp_gfx_data}) begin
                errors++;
                $display("FAIL arb%0d_ack: got %h want %h", n,
                         {cpu_ack_o, gfx_ack_o, cpu_data_o, gfx_data_o}, {!w, w, exp_cpu_data, exp_gfx_data});
            end
            if (w) begin ga = AW'($urandom); gfx_address_i = ga; end
            else   begin ca = AW'($urandom); cpu_address_i = ca; end
            tick();
            checks++;
            if ({cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o} !== 4'b0) begin
                errors++; $display("FAIL arb%0d_idle: got %b want 0000", n, {cpu_ack_o, gfx_ack_o, busy_o, mem_MR_o});
            end
        end
        cpu_req_i = 1'b0; gfx_req_i = 1'b0;
        tick();
    endtask

    task automatic test_gfx_during_write;
        logic [DW-1:0] cap;
        logic [DW-1:0] wd;
        wd = $urandom; cap = '0;
        cpu_req_i = 1'b1; cpu_MR_i = 1'b0; cpu_MW_i = 1'b1; cpu_address_i = 10'h123; cpu_data_i = wd;
        tick();
        checks++;
        if ({mem_MW_o, mem_MR_o, mem_address_o, mem_data_o} !== {2'b10, 10'h123, wd}) begin
            errors++; $display("FAIL late_gfx_wr_issue: got %h want %h", {mem_MW_o, mem_MR_o, mem_address_o, mem_data_o}, {2'b10, 10'h123, wd});
        end
        gfx_req_i = 1'b1; gfx_address_i = 10'h2A5;
        tick();
        checks++;
        if ({cpu_ack_o, gfx_ack_o, mem_MR_o, mem_MW_o} !== 4'b1000) begin
            errors++; $display("FAIL late_gfx_cpu_ack: got %b want 1000", {cpu_ack_o, gfx_ack_o, mem_MR_o, mem_MW_o});
        end
        last_gfx = 1'b0;
        cpu_req_i = 1'b0;
        tick();
        checks++;
        if ({busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o} !== 5'b0) begin
            errors++; $display("FAIL late_gfx_idle: got %b want 00000", {busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o});
        end
        tick();
        checks++;
        if ({mem_MR_o, mem_MW_o, mem_address_o} !== {2'b10, 10'h2A5}) begin
            errors++; $display("FAIL late_gfx_issue: got %h want %h", {mem_MR_o, mem_MW_o, mem_address_o}, {2'b10, 10'h2A5});
        end
        for (int c = 2; c <= RL + 1; c++) begin
            tick();
            if (c == RL + 1) cap = mem_data_i;
        end
        tick();
        exp_gfx_data = cap; last_gfx = 1'b1;
        checks++;
        if ({cpu_ack_o, gfx_ack_o, gfx_data_o, cpu_data_o} !== {2'b01, exp_gfx_data, exp_cpu_data}) begin
            errors++;
            $display("FAIL late_gfx_ack: got %h want %h", {cpu_ack_o, gfx_ack_o, gfx_data_o, cpu_data_o}, {2'b01, exp_gfx_data, exp_cpu_data});
        end
        gfx_req_i = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset;
        cpu_req_i = 1'b1; cpu_MR_i = 1'b1; cpu_MW_i = 1'b0; cpu_address_i = 10'h0F0;
        tick(); tick();
        rst_i = 1'b1; cpu_req_i = 1'b0;
        tick();
        exp_cpu_data = '0; exp_gfx_data = '0; last_gfx = 1'b1;
        checks++;
        if ({busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o, mem_address_o, mem_data_o, cpu_data_o, gfx_data_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {busy_o, mem_MR_o, mem_MW_o, cpu_ack_o, gfx_ack_o, mem_address_o, mem_data_o, cpu_data_o, gfx_data_o});
        end
        rst_i = 1'b0;
        for (int c = 0; c < RL + 4; c++) begin
            tick();
            checks++;
            if ({busy_o, cpu_ack_o, gfx_ack_o} !== 3'b0) begin
                errors++; $display("FAIL mid_reset_quiet%0d: got %b want 000", c, {busy_o, cpu_ack_o, gfx_ack_o});
            end
        end
        run_txn("post_reset_read", 1'b0, 1'b1, 1'b0, AW'($urandom), $urandom);
    endtask

    task automatic test_random;
        for (int n = 0; n < 16; n++) begin
            run_txn($sformatf("rand%0d", n), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), AW'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_gfx_during_write();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
